// File: rtl/line_option_gen_if.sv
// Handshake/bus bundle between the line-option generator and its sequencer.
// master: the sequencer that starts lines and drains the option stream.
// slave:  the generator itself.
interface line_option_gen_if #(
    parameter int SIZE       = 3,
    parameter int MAX_BLOCKS = 2,
    parameter int LEN_W      = $clog2(SIZE + 1),
    parameter int CNT_W      = 7
);
    localparam int KW = $clog2(MAX_BLOCKS + 1);

    logic                        start;
    logic [SIZE-1:0]             line_idx;
    logic [KW-1:0]               num_blocks;
    logic [MAX_BLOCKS*LEN_W-1:0] clue_lens;
    logic [SIZE-1:0]             out_data;
    logic                        out_valid;
    logic                        out_ready;
    logic                        out_is_idx;
    logic                        busy;
    logic                        done;
    logic [CNT_W-1:0]            opt_count;
    logic                        overflow;

    modport master (
        output start, line_idx, num_blocks, clue_lens, out_ready,
        input  out_data, out_valid, out_is_idx, busy, done, opt_count, overflow
    );

    modport slave (
        input  start, line_idx, num_blocks, clue_lens, out_ready,
        output out_data, out_valid, out_is_idx, busy, done, opt_count, overflow
    );
endinterface

// File: rtl/line_option_gen.sv
// Line option generator: enumerates every legal placement of one line's
// clue blocks and streams a line-index header followed by the patterns in
// odometer order (last block moves fastest), one word per accepted cycle.
module line_option_gen #(
    parameter int SIZE       = 3,
    parameter int MAX_BLOCKS = 2,
    parameter int LEN_W      = $clog2(SIZE + 1),
    parameter int CNT_W      = 7
) (
    input  logic              clk,
    input  logic              rst,
    line_option_gen_if.slave  bus
);
    localparam int KW    = $clog2(MAX_BLOCKS + 1);
    localparam int POS_W = LEN_W + 1;
    // Wide enough to hold sum(len+1) over all blocks without wrapping.
    localparam int ACC_W = LEN_W + KW + 2;

    localparam logic [POS_W-1:0] SIZE_P  = POS_W'(SIZE);
    localparam logic [ACC_W-1:0] FIT_LIM = ACC_W'(SIZE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef logic [MAX_BLOCKS-1:0][POS_W-1:0] pos_t;
    typedef logic [MAX_BLOCKS-1:0][LEN_W-1:0] len_t;
    typedef enum logic [2:0] {IDLE, INIT, HDR, EMIT, DONE} state_t;

    state_t           r_state;
    logic [SIZE-1:0]  r_line_idx;
    logic [KW-1:0]    r_k;
    len_t             r_len;
    pos_t             r_pos;
    logic             r_feasible;
    logic [SIZE-1:0]  r_out_data;
    logic             r_out_valid;
    logic             r_out_is_idx;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;

    int               w_k;
    pos_t             w_init_pos;
    logic [ACC_W-1:0] w_acc;
    logic             w_feasible;
    pos_t             w_lim;
    int               w_sel;
    logic             w_has_next;
    pos_t             w_next_pos;
    logic [SIZE-1:0]  w_pat_cur;
    logic [SIZE-1:0]  w_pat_next;

    // Cell pattern for a set of block positions; blocks at or beyond k are ignored.
    function automatic logic [SIZE-1:0] f_pattern(input pos_t pos, input len_t len, input int k);
        logic [SIZE-1:0] pat;
        pat = '0;
        for (int i = 0; i < MAX_BLOCKS; i++) begin
            if (i < k) begin
                for (int c = 0; c < SIZE; c++) begin
                    if ((POS_W'(c) >= pos[i]) && (POS_W'(c) < pos[i] + POS_W'(len[i])))
                        pat[c] = 1'b1;
                end
            end
        end
        return pat;
    endfunction

    // Latched block count as a loop-friendly integer.
    always_comb w_k = int'(r_k);

    // Leftmost packing and feasibility: fits when sum(len+1) <= SIZE+1.
    always_comb begin
        w_init_pos = '0;
        w_acc      = '0;
        for (int i = 1; i < MAX_BLOCKS; i++)
            w_init_pos[i] = w_init_pos[i-1] + POS_W'(r_len[i-1]) + POS_W'(1);
        for (int i = 0; i < MAX_BLOCKS; i++)
            if (i < w_k) w_acc = w_acc + ACC_W'(r_len[i]) + ACC_W'(1);
        w_feasible = (w_k == 0) || (w_acc <= FIT_LIM);
    end

    // Odometer step: shift the rightmost movable block, repack the ones after it.
    always_comb begin
        w_lim = '0;
        w_sel = -1;
        for (int i = 0; i < MAX_BLOCKS - 1; i++)
            w_lim[i] = r_pos[i+1];
        for (int i = 0; i < MAX_BLOCKS; i++) begin
            if (i < w_k) begin
                if (i == w_k - 1) begin
                    if (r_pos[i] + POS_W'(r_len[i]) < SIZE_P) w_sel = i;
                end else if (r_pos[i] + POS_W'(r_len[i]) + POS_W'(1) < w_lim[i]) begin
                    w_sel = i;
                end
            end
        end
        w_has_next = (w_sel >= 0);
        w_next_pos = r_pos;
        for (int i = 0; i < MAX_BLOCKS; i++)
            if (i == w_sel) w_next_pos[i] = r_pos[i] + POS_W'(1);
        for (int i = 1; i < MAX_BLOCKS; i++)
            if (w_has_next && (i > w_sel) && (i < w_k))
                w_next_pos[i] = w_next_pos[i-1] + POS_W'(r_len[i-1]) + POS_W'(1);
    end

    assign w_pat_cur  = f_pattern(r_pos, r_len, w_k);
    assign w_pat_next = f_pattern(w_next_pos, r_len, w_k);

    // Control FSM; every output is registered so the stream word is glitch-free
    // and naturally held while the downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_line_idx   <= '0;
            r_k          <= '0;
            r_len        <= '0;
            r_pos        <= '0;
            r_feasible   <= 1'b0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_out_is_idx <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_count      <= '0;
            r_ovf        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_line_idx <= bus.line_idx;
                        r_k        <= bus.num_blocks;
                        r_len      <= bus.clue_lens;
                        r_count    <= '0;
                        r_ovf      <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= INIT;
                    end
                end
                INIT: begin
                    r_pos        <= w_init_pos;
                    r_feasible   <= w_feasible;
                    r_out_data   <= r_line_idx;
                    r_out_is_idx <= 1'b1;
                    r_out_valid  <= 1'b1;
                    r_state      <= HDR;
                end
                HDR: begin
                    if (bus.out_ready) begin
                        r_out_is_idx <= 1'b0;
                        if (r_feasible) begin
                            r_out_data <= w_pat_cur;
                            r_state    <= EMIT;
                        end else begin
                            r_out_valid <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= DONE;
                        end
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        if (r_count == CNT_MAX) r_ovf <= 1'b1;
                        else                    r_count <= r_count + CNT_W'(1);
                        if (w_has_next) begin
                            r_pos      <= w_next_pos;
                            r_out_data <= w_pat_next;
                        end else begin
                            r_out_valid <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.out_data   = r_out_data;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_is_idx = r_out_is_idx;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.opt_count  = r_count;
    assign bus.overflow   = r_ovf;
endmodule

// File: tb/tb_line_option_gen.sv
// Bench for line_option_gen: table of clues with expected option lists,
// scoreboard queue filled at start and drained on each stream transfer.
module tb_line_option_gen;
    localparam int SIZE       = 3;
    localparam int MAX_BLOCKS = 2;
    localparam int CNT_W      = 7;

    typedef struct packed {
        logic [1:0] k;
        logic [3:0] lens;   // block0 in [1:0], block1 in [3:2]
        logic [2:0] idx;
        logic [2:0] nopt;
        logic [8:0] opts;   // option j in [3j+2:3j]
    } vec_t;

    logic clk;
    logic rst;

    line_option_gen_if #(.SIZE(SIZE), .MAX_BLOCKS(MAX_BLOCKS), .CNT_W(CNT_W)) bus ();

    line_option_gen #(.SIZE(SIZE), .MAX_BLOCKS(MAX_BLOCKS), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t       vecs[7];
    logic [3:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         hdr_cyc = 0;
    int         exp_cnt = 0;
    bit         done_seen = 0;
    bit         stall_mode = 0;
    bit         prev_stall = 0;
    logic [3:0] prev_word = '0;

    function automatic vec_t mk(input logic [1:0] k, input logic [3:0] lens, input logic [2:0] idx,
                                input logic [2:0] nopt, input logic [8:0] opts);
        vec_t v;
        v.k = k; v.lens = lens; v.idx = idx; v.nopt = nopt; v.opts = opts;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Per-cycle observer, called at the falling edge.
    task automatic mon();
        logic [3:0] act;
        cyc++;
        act = {bus.out_is_idx, bus.out_data};
        if (prev_stall) begin
            chk("hold_valid", int'(bus.out_valid), 1);
            chk("hold_word", int'(act), int'(prev_word));
        end
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_word actual=%0h required=none", act);
            end else begin
                chk("word", int'(act), int'(exp_q.pop_front()));
                if (bus.out_is_idx) hdr_cyc = cyc;
            end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_word  = act;
        if (bus.done) begin
            chk("opt_count", int'(bus.opt_count), exp_cnt);
            chk("overflow", int'(bus.overflow), 0);
            chk("busy_on_done", int'(bus.busy), 1);
            chk("valid_on_done", int'(bus.out_valid), 0);
            chk("words_left", exp_q.size(), 0);
            if (!stall_mode) chk("done_latency", cyc - hdr_cyc, exp_cnt + 1);
            done_seen = 1;
        end
    endtask

    task automatic run_vec(input vec_t v, input bit stall);
        exp_q.delete();
        exp_q.push_back({1'b1, v.idx});
        for (int j = 0; j < int'(v.nopt); j++) exp_q.push_back({1'b0, v.opts[3*j +: 3]});
        exp_cnt    = int'(v.nopt);
        stall_mode = stall;
        done_seen  = 0;
        prev_stall = 0;
        hdr_cyc    = cyc;
        @(posedge clk); #1;
        bus.start      = 1'b1;
        bus.num_blocks = v.k;
        bus.clue_lens  = v.lens;
        bus.line_idx   = v.idx;
        bus.out_ready  = 1'b1;
        for (int c = 0; c < 60 && !done_seen; c++) begin
            @(posedge clk); #1;
            bus.start = stall && (c == 3);
            if (stall && c == 3) begin
                bus.num_blocks = 2'd0;
                bus.line_idx   = 3'd7;
            end
            bus.out_ready = stall ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
            @(negedge clk);
            if (c == 0) begin
                chk("init_valid", int'(bus.out_valid), 0);
                chk("init_busy", int'(bus.busy), 1);
            end
            if (c == 1) chk("hdr_latency", int'({bus.out_valid, bus.out_is_idx}), 3);
            mon();
        end
        if (!done_seen) begin
            checks++;
            errors++;
            $display("FAIL timeout actual=no_done required=done");
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("idle_busy", int'(bus.busy), 0);
        chk("idle_done", int'(bus.done), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk(2'd1, 4'b0001, 3'd2, 3'd3, {3'b100, 3'b010, 3'b001});
        vecs[1] = mk(2'd2, 4'b0101, 3'd4, 3'd1, {3'b000, 3'b000, 3'b101});
        vecs[2] = mk(2'd1, 4'b0011, 3'd1, 3'd1, {3'b000, 3'b000, 3'b111});
        vecs[3] = mk(2'd0, 4'b0000, 3'd0, 3'd1, {3'b000, 3'b000, 3'b000});
        vecs[4] = mk(2'd2, 4'b1010, 3'd3, 3'd0, 9'd0);
        vecs[5] = mk(2'd1, 4'b0010, 3'd5, 3'd2, {3'b000, 3'b110, 3'b011});
        vecs[6] = mk(2'd1, 4'b1101, 3'd5, 3'd3, {3'b100, 3'b010, 3'b001});

        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.line_idx   = '0;
        bus.num_blocks = '0;
        bus.clue_lens  = '0;
        bus.out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data", int'(bus.out_data), 0);
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_is_idx", int'(bus.out_is_idx), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_count", int'(bus.opt_count), 0);
        chk("rst_overflow", int'(bus.overflow), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], 1'b0);

        // Back-pressure with a start pulse landing mid-line.
        run_vec(vecs[0], 1'b1);

        // Reset while streaming options.
        @(posedge clk); #1;
        bus.start      = 1'b1;
        bus.num_blocks = 2'd1;
        bus.clue_lens  = 4'b0001;
        bus.line_idx   = 3'd2;
        bus.out_ready  = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        @(negedge clk);
        chk("pre_rst_emit", int'({bus.out_valid, bus.out_is_idx}), 2);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", int'(bus.out_valid), 0);
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_done", int'(bus.done), 0);
        chk("mid_rst_count", int'(bus.opt_count), 0);
        run_vec(vecs[5], 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
